// File: rtl/cnt_alarm_if.sv
// rtl/cnt_alarm_if.sv - counter input, configuration and event-drain signals of cnt_alarm
interface cnt_alarm_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] cnt;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_start;
   logic [WIDTH-1:0] cfg_period;
   logic             stop;
   logic             armed;
   logic             evt_valid;
   logic             evt_ready;
   logic [WIDTH-1:0] evt_stamp;
   logic [7:0]       evt_seq;
   logic             ovf;

   modport master (
      output cnt, cfg_valid, cfg_start, cfg_period, stop, evt_ready,
      input  cfg_ready, armed, evt_valid, evt_stamp, evt_seq, ovf
   );

   modport slave (
      input  cnt, cfg_valid, cfg_start, cfg_period, stop, evt_ready,
      output cfg_ready, armed, evt_valid, evt_stamp, evt_seq, ovf
   );
endinterface

// File: rtl/cnt_alarm.sv
// rtl/cnt_alarm.sv - compare-match event generator with timestamped event FIFO
module cnt_alarm #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        rst,
   cnt_alarm_if.slave alarm_if
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [7:0]       seq_q, seq_d;
   logic             ovf_q, ovf_d;
   logic             push;

   logic [WIDTH-1:0] stamp_mem_q [DEPTH];
   logic [7:0]       seq_mem_q   [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic             fifo_empty, fifo_full, pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop        = !fifo_empty && alarm_if.evt_ready;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      period_d = period_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      push     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (alarm_if.cfg_valid) begin
               target_d = alarm_if.cfg_start;
               period_d = alarm_if.cfg_period;
               seq_d    = 8'd0;
               ovf_d    = 1'b0;
               state_d  = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (alarm_if.stop) begin
               state_d = ST_IDLE;
            end else if (alarm_if.cnt == target_q) begin
               // A same-cycle pop frees a slot, so a full FIFO still accepts.
               push  = !fifo_full || pop;
               ovf_d = ovf_q || !push;
               seq_d = seq_q + 8'd1;
               if (period_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  target_d = target_q + period_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         target_q <= '0;
         period_q <= '0;
         seq_q    <= 8'd0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            stamp_mem_q[i] <= '0;
            seq_mem_q[i]   <= 8'd0;
         end
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         period_q <= period_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
         if (push) begin
            stamp_mem_q[wr_ptr_q[AW-1:0]] <= alarm_if.cnt;
            seq_mem_q[wr_ptr_q[AW-1:0]]   <= seq_q;
            wr_ptr_q                      <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   assign alarm_if.cfg_ready = (state_q == ST_IDLE);
   assign alarm_if.armed     = (state_q == ST_ARMED);
   assign alarm_if.ovf       = ovf_q;
   assign alarm_if.evt_valid = !fifo_empty;
   assign alarm_if.evt_stamp = fifo_empty ? '0 : stamp_mem_q[rd_ptr_q[AW-1:0]];
   assign alarm_if.evt_seq   = fifo_empty ? 8'd0 : seq_mem_q[rd_ptr_q[AW-1:0]];
endmodule
